// File: rtl/dab_gate_pkg.sv
// Shared types and constants for the DAB gate driver: leg states, bridge level codes,
// gate-bit positions within Sp/Ss and the level-to-leg-target decode.
package dab_gate_pkg;

    typedef enum logic [1:0] {
        LEG_OFF = 2'd0,
        LEG_DT  = 2'd1,
        LEG_HI  = 2'd2,
        LEG_LO  = 2'd3
    } leg_state_t;

    localparam logic [1:0] LVL_POS  = 2'b01;
    localparam logic [1:0] LVL_ZERO = 2'b00;
    localparam logic [1:0] LVL_NEG  = 2'b11;
    localparam logic [1:0] LVL_BAD  = 2'b10;

    localparam int IDX_A_HI = 0;
    localparam int IDX_A_LO = 1;
    localparam int IDX_B_HI = 2;
    localparam int IDX_B_LO = 3;

    localparam int DT_MIN_DEF = 2;

    // Per-bridge leg targets: 1 = high switch, 0 = low switch.
    typedef struct packed {
        logic b_hi;
        logic a_hi;
    } leg_tgt_t;

    // The illegal code decodes like level 0 (both legs low).
    function automatic leg_tgt_t lvl_to_tgt(input logic [1:0] lvl);
        leg_tgt_t t;
        t = '0;
        case (lvl)
            LVL_POS:           t.a_hi = 1'b1;
            LVL_NEG:           t.b_hi = 1'b1;
            LVL_ZERO, LVL_BAD: t = '0;
            default:           t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/dab_gate_driver_if.sv
// Control, level and gate bundle between the voltage generator side and dab_gate_driver.
// st_err only exists when SHOOT_THROUGH_CHECK_EN is defined.
interface dab_gate_driver_if #(
    parameter int DT_W = 8
) ();
    logic            CE;
    logic            en;
    logic            fault;
    logic            fault_clr;
    logic [DT_W-1:0] deadtime;
    logic [1:0]      V1;
    logic [1:0]      V2;
    logic [3:0]      Sp;
    logic [3:0]      Ss;
    logic            flt_latched;
    logic            code_err;
`ifdef SHOOT_THROUGH_CHECK_EN
    logic            st_err;

    modport master (
        output CE, en, fault, fault_clr, deadtime, V1, V2,
        input  Sp, Ss, flt_latched, code_err, st_err
    );
    modport slave (
        input  CE, en, fault, fault_clr, deadtime, V1, V2,
        output Sp, Ss, flt_latched, code_err, st_err
    );
`else
    modport master (
        output CE, en, fault, fault_clr, deadtime, V1, V2,
        input  Sp, Ss, flt_latched, code_err
    );
    modport slave (
        input  CE, en, fault, fault_clr, deadtime, V1, V2,
        output Sp, Ss, flt_latched, code_err
    );
`endif
endinterface

// File: rtl/dab_leg_deadtime.sv
// One half-bridge leg: OFF/DT/HI/LO FSM with dead-time down-counter and registered hi/lo.
// Dead time lasts max(deadtime, DT_MIN) enabled cycles; gate_ok low forces OFF regardless of ce.
module dab_leg_deadtime
    import dab_gate_pkg::*;
#(
    parameter int DT_W   = 8,
    parameter int DT_MIN = DT_MIN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce_i,
    input  logic            gate_ok_i,
    input  logic            tgt_hi_i,
    input  logic [DT_W-1:0] deadtime_i,
    output logic            hi_o,
    output logic            lo_o
);
    localparam logic [DT_W-1:0] DT_FLOOR = DT_W'(DT_MIN);
    localparam logic [DT_W-1:0] CNT_ONE  = DT_W'(1);

    leg_state_t      state_q, state_d;
    leg_state_t      tgt_state;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic [DT_W-1:0] dt_load;
    logic            hi_q, hi_d, lo_q, lo_d;

    assign tgt_state = tgt_hi_i ? LEG_HI : LEG_LO;
    assign dt_load   = (deadtime_i < DT_FLOOR) ? DT_FLOOR : deadtime_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LEG_OFF;
            cnt_q   <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // The target is only consulted at expiry, so a mid-DT change neither restarts nor shortens it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!gate_ok_i) begin
            state_d = LEG_OFF;
            cnt_d   = '0;
        end else if (ce_i) begin
            case (state_q)
                LEG_OFF: begin
                    state_d = LEG_DT;
                    cnt_d   = dt_load;
                end
                LEG_HI, LEG_LO: begin
                    if (state_q != tgt_state) begin
                        state_d = LEG_DT;
                        cnt_d   = dt_load;
                    end
                end
                LEG_DT: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = tgt_state;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = LEG_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        hi_d = gate_ok_i && (state_q == LEG_HI);
        lo_d = gate_ok_i && (state_q == LEG_LO);
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/dab_gate_driver.sv
// DAB gate driver: bridge levels V1/V2 -> 8 dead-time-protected gates; latency 1 + DT + 1 cycles.
// Fault latch, enable gating, illegal-code flag; SHOOT_THROUGH_CHECK_EN adds a sticky overlap checker.
module dab_gate_driver
    import dab_gate_pkg::*;
#(
    parameter int DT_W   = 8,
    parameter int DT_MIN = DT_MIN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    dab_gate_driver_if.slave  bus
);
    logic [1:0] v1_q, v1_d, v2_q, v2_d;
    logic       bad_q, bad_d;
    logic       cerr_q, cerr_d;
    logic       flt_q, flt_d;
    logic       in_bad;
    logic       gate_ok;
    leg_tgt_t   tgt_p, tgt_s;
    logic [3:0] leg_tgt, leg_hi, leg_lo;
    logic [3:0] sp_raw, ss_raw;

    assign in_bad = (bus.V1 == LVL_BAD) || (bus.V2 == LVL_BAD);

    // The fault latch ignores CE so a fault is never masked by a stalled pipeline.
    always_comb begin
        v1_d   = bus.CE ? bus.V1 : v1_q;
        v2_d   = bus.CE ? bus.V2 : v2_q;
        bad_d  = bus.CE ? in_bad : bad_q;
        cerr_d = bus.CE && in_bad && !bad_q;
        flt_d  = bus.fault ? 1'b1 : (bus.fault_clr ? 1'b0 : flt_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q   <= LVL_ZERO;
            v2_q   <= LVL_ZERO;
            bad_q  <= 1'b0;
            cerr_q <= 1'b0;
            flt_q  <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            bad_q  <= bad_d;
            cerr_q <= cerr_d;
            flt_q  <= flt_d;
        end
    end

    // Raw fault also gates, so the first fault cycle already clears the output register.
    assign gate_ok = bus.en && !bus.fault && !flt_q;
    assign tgt_p   = lvl_to_tgt(v1_q);
    assign tgt_s   = lvl_to_tgt(v2_q);
    assign leg_tgt = {tgt_s.b_hi, tgt_s.a_hi, tgt_p.b_hi, tgt_p.a_hi};

    for (genvar g = 0; g < 4; g++) begin : g_leg
        dab_leg_deadtime #(
            .DT_W   (DT_W),
            .DT_MIN (DT_MIN)
        ) u_leg (
            .clk        (clk),
            .rst        (rst),
            .ce_i       (bus.CE),
            .gate_ok_i  (gate_ok),
            .tgt_hi_i   (leg_tgt[g]),
            .deadtime_i (bus.deadtime),
            .hi_o       (leg_hi[g]),
            .lo_o       (leg_lo[g])
        );
    end

    always_comb begin
        sp_raw           = '0;
        ss_raw           = '0;
        sp_raw[IDX_A_HI] = leg_hi[0];
        sp_raw[IDX_A_LO] = leg_lo[0];
        sp_raw[IDX_B_HI] = leg_hi[1];
        sp_raw[IDX_B_LO] = leg_lo[1];
        ss_raw[IDX_A_HI] = leg_hi[2];
        ss_raw[IDX_A_LO] = leg_lo[2];
        ss_raw[IDX_B_HI] = leg_hi[3];
        ss_raw[IDX_B_LO] = leg_lo[3];
    end

`ifdef SHOOT_THROUGH_CHECK_EN
    logic sp_st, ss_st;
    logic st_err_q, st_err_d;

    assign sp_st    = (sp_raw[IDX_A_HI] && sp_raw[IDX_A_LO]) || (sp_raw[IDX_B_HI] && sp_raw[IDX_B_LO]);
    assign ss_st    = (ss_raw[IDX_A_HI] && ss_raw[IDX_A_LO]) || (ss_raw[IDX_B_HI] && ss_raw[IDX_B_LO]);
    assign st_err_d = st_err_q || sp_st || ss_st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_err_q <= 1'b0;
        end else begin
            st_err_q <= st_err_d;
        end
    end

    assign bus.Sp     = sp_st ? 4'b0000 : sp_raw;
    assign bus.Ss     = ss_st ? 4'b0000 : ss_raw;
    assign bus.st_err = st_err_q;
`else
    assign bus.Sp = sp_raw;
    assign bus.Ss = ss_raw;
`endif

    assign bus.flt_latched = flt_q;
    assign bus.code_err    = cerr_q;

endmodule

// File: tb/tb_dab_gate_driver.sv
// Directed scenarios followed by random traffic, every cycle compared against a leg-level reference model.
module tb_dab_gate_driver;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dab_gate_driver_if #(.DT_W(8)) bus ();

    dab_gate_driver #(
        .DT_W   (8),
        .DT_MIN (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: legs 0..3 = primary A, primary B, secondary A, secondary B.
    int m_on   [4];
    int m_dt   [4];
    int m_side [4];
    bit m_hi   [4];
    bit m_lo   [4];
    int m_lv1, m_lv2;
    bit m_bad, m_cerr, m_flt;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int lvl(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b11:   return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int leg_target(input int l);
        int lv;
        lv = (l < 2) ? m_lv1 : m_lv2;
        if (l % 2 == 0) return (lv > 0) ? 1 : -1;
        return (lv < 0) ? 1 : -1;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < 4; l++) begin
            m_on[l] = 0; m_dt[l] = 0; m_side[l] = 0; m_hi[l] = 0; m_lo[l] = 0;
        end
        m_lv1 = 0; m_lv2 = 0; m_bad = 0; m_cerr = 0; m_flt = 0;
    endtask

    task automatic model_edge();
        bit gate;
        bit bad_in;
        int dtl;
        int tg;
        gate = bus.en && !bus.fault && !m_flt;
        dtl  = (int'(bus.deadtime) < 2) ? 2 : int'(bus.deadtime);
        for (int l = 0; l < 4; l++) begin
            tg = leg_target(l);
            m_hi[l] = gate && (m_on[l] != 0) && (m_dt[l] == 0) && (m_side[l] == 1);
            m_lo[l] = gate && (m_on[l] != 0) && (m_dt[l] == 0) && (m_side[l] == -1);
            if (!gate) begin
                m_on[l] = 0;
                m_dt[l] = 0;
            end else if (bus.CE) begin
                if (m_on[l] == 0) begin
                    m_on[l] = 1;
                    m_dt[l] = dtl;
                end else if (m_dt[l] > 0) begin
                    m_dt[l] = m_dt[l] - 1;
                    if (m_dt[l] == 0) m_side[l] = tg;
                end else if (m_side[l] != tg) begin
                    m_dt[l] = dtl;
                end
            end
        end
        bad_in = (bus.V1 == 2'b10) || (bus.V2 == 2'b10);
        m_cerr = bus.CE && bad_in && !m_bad;
        if (bus.CE) begin
            m_bad = bad_in;
            m_lv1 = lvl(bus.V1);
            m_lv2 = lvl(bus.V2);
        end
        m_flt = bus.fault ? 1'b1 : (bus.fault_clr ? 1'b0 : m_flt);
    endtask

    task automatic check_all();
        logic [3:0] ov;
        chk("Sp", bus.Sp, {m_lo[1], m_hi[1], m_lo[0], m_hi[0]});
        chk("Ss", bus.Ss, {m_lo[3], m_hi[3], m_lo[2], m_hi[2]});
        chk("flt_latched", {3'b000, bus.flt_latched}, {3'b000, m_flt});
        chk("code_err", {3'b000, bus.code_err}, {3'b000, m_cerr});
        ov = {2'b00, (bus.Ss[0] & bus.Ss[1]) | (bus.Ss[2] & bus.Ss[3]),
                     (bus.Sp[0] & bus.Sp[1]) | (bus.Sp[2] & bus.Sp[3])};
        chk("no_overlap", ov, 4'b0000);
`ifdef SHOOT_THROUGH_CHECK_EN
        chk("st_err", {3'b000, bus.st_err}, 4'b0000);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        check_all();
    endtask

    initial begin
        bus.CE = 1'b1; bus.en = 1'b1; bus.fault = 1'b0; bus.fault_clr = 1'b0;
        bus.deadtime = 8'd5; bus.V1 = 2'b01; bus.V2 = 2'b00;
        model_reset();
        #1;
        chk("rst_Sp", bus.Sp, 4'b0000);
        chk("rst_Ss", bus.Ss, 4'b0000);
        chk("rst_flt", {3'b000, bus.flt_latched}, 4'b0000);
        chk("rst_cerr", {3'b000, bus.code_err}, 4'b0000);
        tick(); tick();
        rst = 1'b1;

        // Power-up: 1 + 5 + 1 cycles of all-off, then +1 on the primary.
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t1_dead", bus.Sp, 4'b0000);
        end
        tick();
        chk("t1_on", bus.Sp, 4'b1001);
        chk("t1_ss", bus.Ss, 4'b1010);

        // +1 -> -1: old switches hold two cycles, then exactly 5 dead cycles.
        bus.V1 = 2'b11;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t2_old", bus.Sp, 4'b1001);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_dead", bus.Sp, 4'b0000);
        end
        tick();
        chk("t2_new", bus.Sp, 4'b0110);

        // Programmed 0 is floored to 2 dead cycles.
        bus.deadtime = 8'd0; bus.V2 = 2'b01;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t3_old", bus.Ss, 4'b1010);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t3_dead", bus.Ss, 4'b1000);
        end
        tick();
        chk("t3_new", bus.Ss, 4'b1001);

        // Target changes mid-DT: one uninterrupted 6-cycle DT, newest target wins.
        bus.deadtime = 8'd6; bus.V1 = 2'b01;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t4_old", bus.Sp, 4'b0110);
        end
        tick();
        chk("t4_dead", bus.Sp, 4'b0000);
        bus.V1 = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_dead", bus.Sp, 4'b0000);
        end
        tick();
        chk("t4_new", bus.Sp, 4'b1010);
        bus.V1 = 2'b11;
        for (int i = 0; i < 12; i++) tick();
        chk("t4_settle", bus.Sp, 4'b0110);

        // Fault during a transition, stickiness, priority over clear, DT re-entry.
        bus.V1 = 2'b01;
        for (int i = 0; i < 3; i++) tick();
        bus.fault = 1'b1;
        tick();
        chk("t5_sp_off", bus.Sp, 4'b0000);
        chk("t5_ss_off", bus.Ss, 4'b0000);
        chk("t5_flt", {3'b000, bus.flt_latched}, 4'b0001);
        bus.fault = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_sticky", {3'b000, bus.flt_latched}, 4'b0001);
        end
        bus.fault = 1'b1; bus.fault_clr = 1'b1;
        tick();
        chk("t5_fault_wins", {3'b000, bus.flt_latched}, 4'b0001);
        bus.fault = 1'b0;
        tick();
        chk("t5_clr", {3'b000, bus.flt_latched}, 4'b0000);
        bus.fault_clr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t5_reentry_dt", bus.Sp, 4'b0000);
        end
        tick();
        chk("t5_sp_on", bus.Sp, 4'b1001);
        chk("t5_ss_on", bus.Ss, 4'b1001);

        // Illegal code: single pulse, bridge treated as level 0.
        bus.V1 = 2'b10;
        tick();
        chk("t6_pulse", {3'b000, bus.code_err}, 4'b0001);
        tick();
        chk("t6_once", {3'b000, bus.code_err}, 4'b0000);
        for (int i = 0; i < 10; i++) tick();
        chk("t6_zero", bus.Sp, 4'b1010);

        // CE low for 10 cycles mid-DT stretches the DT by exactly 10.
        bus.deadtime = 8'd5; bus.V1 = 2'b01;
        for (int i = 0; i < 3; i++) tick();
        bus.CE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_hold", bus.Sp, 4'b1000);
        end
        bus.CE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_dt", bus.Sp, 4'b1000);
        end
        tick();
        chk("t6_on", bus.Sp, 4'b1001);

        // Asynchronous reset mid-operation.
        #2;
        rst = 1'b0;
        #1;
        chk("arst_Sp", bus.Sp, 4'b0000);
        chk("arst_Ss", bus.Ss, 4'b0000);
        chk("arst_flt", {3'b000, bus.flt_latched}, 4'b0000);
        model_reset();
        tick();
        rst = 1'b1;

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) bus.V1 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) bus.V2 = 2'($urandom_range(0, 3));
            bus.deadtime  = 8'($urandom_range(0, 9));
            bus.CE        = ($urandom_range(0, 9) != 0);
            bus.en        = ($urandom_range(0, 39) != 0);
            bus.fault     = ($urandom_range(0, 59) == 0);
            bus.fault_clr = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
